mux7_rr_scheduler: RTL

MUX7_RR_SCHEDULER -- requirements
Module: mux7_rr_scheduler

---
 rtl/mux7_rr_scheduler.sv | 119 +++++++++++
 1 files changed

// File: rtl/mux7_rr_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : mux7_rr_scheduler                                          |
// | Description : 7:1 serial data mux with burst-based round-robin grants.   |
// |               MUX7_SCHED_FIXED_PRIORITY_EN selects lowest-index-wins.    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module mux7_rr_scheduler #(
    parameter int BURST_LEN = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [6:0] req,
    input  logic [6:0] data_in,
    input  logic       out_ready,
    output logic       out_data,
    output logic       out_valid,
    output logic [2:0] mux_sel,
    output logic [6:0] grant,
    output logic       busy
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SERVE = 1'b1
    } state_t;

    localparam logic [3:0] c_last_beat = 4'(BURST_LEN - 1);
    localparam logic [2:0] c_no_src    = 3'b111;

    state_t     r_state, w_state_nxt;
    logic [2:0] r_owner, w_owner_nxt;
    logic [2:0] r_last,  w_last_nxt;
    logic [3:0] r_beat_cnt, w_beat_cnt_nxt;
    logic [2:0] w_win;

`ifdef MUX7_SCHED_FIXED_PRIORITY_EN
    function automatic logic [2:0] pick_winner(input logic [6:0] r, input logic [2:0] lst);
        logic [2:0] pick;
        pick = 3'd0;
        for (int i = 6; i >= 0; i--) begin
            if (r[i]) pick = 3'(i);
        end
        return pick;
    endfunction
`else
    // Search starts one past the last released owner and wraps 6 -> 0.
    function automatic logic [2:0] pick_winner(input logic [6:0] r, input logic [2:0] lst);
        logic [2:0] pick;
        logic [2:0] idx;
        logic       found;
        pick  = 3'd0;
        idx   = lst;
        found = 1'b0;
        for (int k = 0; k < 7; k++) begin
            idx = (idx == 3'd6) ? 3'd0 : idx + 3'd1;
            if (!found && r[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction
`endif

    assign w_win = pick_winner(req, r_last);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_owner    <= 3'd0;
            r_last     <= 3'd6;
            r_beat_cnt <= 4'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_owner    <= w_owner_nxt;
            r_last     <= w_last_nxt;
            r_beat_cnt <= w_beat_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_owner_nxt    = r_owner;
        w_last_nxt     = r_last;
        w_beat_cnt_nxt = r_beat_cnt;
        out_data       = 1'b0;
        out_valid      = 1'b0;
        mux_sel        = c_no_src;
        grant          = 7'd0;
        busy           = 1'b0;
        case (r_state)
            IDLE: begin
                if (req != 7'd0) begin
                    w_state_nxt    = SERVE;
                    w_owner_nxt    = w_win;
                    w_beat_cnt_nxt = 4'd0;
                end
            end
            SERVE: begin
                out_data  = data_in[r_owner];
                out_valid = 1'b1;
                mux_sel   = r_owner;
                grant     = 7'd1 << r_owner;
                busy      = 1'b1;
                // A dropped request ends the burst even if a beat lands on this edge.
                if (!req[r_owner] || (out_ready && r_beat_cnt == c_last_beat)) begin
                    w_state_nxt = IDLE;
                    w_last_nxt  = r_owner;
                end else if (out_ready) begin
                    w_beat_cnt_nxt = r_beat_cnt + 4'd1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

endmodule
`default_nettype wire
